// File: rtl/bram_piece_responder.sv
// Piece-addressed BRAM responder: 2-cycle write-first read path, regce-gated output register,
// 1-entry init buffer that drains when the client is not writing. BRAM_RESPONDER_STATS_EN adds counters.
module bram_piece_responder #(
  parameter int BRAM_WIDTH  = 64,
  parameter int BRAM_DEPTH  = 32768,
  parameter int COUNT_WIDTH = 32,
  localparam int BRAM_ADDR_SIZE = $clog2(BRAM_DEPTH)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [BRAM_ADDR_SIZE-1:0] bram_addr,
  input  logic                      bram_we,
  input  logic                      bram_regce,
  input  logic [BRAM_WIDTH-1:0]     bram_din,
  output logic [BRAM_WIDTH-1:0]     bram_dout,
  input  logic                      init_valid,
  output logic                      init_ready,
  input  logic [BRAM_ADDR_SIZE-1:0] init_addr,
  input  logic [BRAM_WIDTH-1:0]     init_data,
  output logic                      oob_out
`ifdef BRAM_RESPONDER_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0]    write_count_out,
  output logic [COUNT_WIDTH-1:0]    read_count_out
`endif
);

  // state | meaning
  // EMPTY | init buffer free, init_ready=1
  // FULL  | init piece held, waiting for a cycle with bram_we=0 to drain
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} init_state_t;

  localparam logic [BRAM_ADDR_SIZE:0] DEPTH_L = (BRAM_ADDR_SIZE+1)'(BRAM_DEPTH);

  logic [BRAM_WIDTH-1:0]     mem [0:BRAM_DEPTH-1];
  logic [BRAM_WIDTH-1:0]     stage1_q;
  logic [BRAM_ADDR_SIZE-1:0] buf_addr_q;
  logic [BRAM_WIDTH-1:0]     buf_data_q;
  init_state_t               state_q, state_next;
  logic                      accept, drain;
  logic                      client_in_range, buf_in_range;
  logic                      mem_we;
  logic [BRAM_ADDR_SIZE-1:0] mem_waddr;
  logic [BRAM_WIDTH-1:0]     mem_wdata;

  assign client_in_range = ({1'b0, bram_addr} < DEPTH_L);
  assign buf_in_range    = ({1'b0, buf_addr_q} < DEPTH_L);
  assign init_ready      = (state_q == EMPTY);

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= EMPTY;
    else        state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    accept     = 1'b0;
    drain      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (init_valid) begin
          accept     = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (!bram_we) begin
          drain      = 1'b1;
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Single write port: the client wins, drains only use cycles the client leaves idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bram_addr;
    mem_wdata = bram_din;
    if (!rst_in) begin
      if (bram_we) begin
        mem_we = client_in_range;
      end else if (drain) begin
        mem_we    = buf_in_range;
        mem_waddr = buf_addr_q;
        mem_wdata = buf_data_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stage1_q   <= '0;
      bram_dout  <= '0;
      oob_out    <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      if (accept) begin
        buf_addr_q <= init_addr;
        buf_data_q <= init_data;
      end
      if (!client_in_range)  stage1_q <= '0;
      else if (bram_we)      stage1_q <= bram_din;
      else                   stage1_q <= mem[bram_addr];
      if (bram_regce) bram_dout <= stage1_q;
      if (!client_in_range || (drain && !buf_in_range)) oob_out <= 1'b1;
    end
  end

`ifdef BRAM_RESPONDER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      write_count_out <= '0;
      read_count_out  <= '0;
    end else begin
      if (bram_we && client_in_range) write_count_out <= write_count_out + COUNT_WIDTH'(1);
      if (bram_regce)                 read_count_out  <= read_count_out + COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
